alu_muldiv: RTL
===============

Name: alu_muldiv

Overview:
- Parametrised successor to the single-cycle datapath ALU.
- Executes the single-cycle integer ops combinationally.
- Adds an iterative multiply/divide unit with architectural HI/LO registers and a valid/ready/done handshake.
- Sits in the EX stage. Control stalls the core while ready_o is low and a multi-cycle op or HI/LO read is pending.

Parameters:
- WIDTH, 32: operand, result, HI and LO width. Must be ≥4 and even.
- SHW, 5: shift-amount bits used from src1_i; must equal log2(WIDTH).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- valid_i  in  1  op request this cycle.
- ctrl_i  in  5  op code.
- src1_i  in  WIDTH  operand A; shift amount for shifts.
- src2_i  in  WIDTH  operand B.
- ready_o  out  1  unit can accept a request.
- result_o  out  WIDTH  combinational result.
- zero_o  out  1  result_o == 0.
- ovf_o  out  1  signed overflow, ADD/SUB only.
- done_o  out  1  one-cycle pulse when a MULT/DIV result is written to HI/LO.
- hi_o  out  WIDTH  HI register.
- lo_o  out  WIDTH  LO register.

Behaviour:
- Op codes:
  - 00000 NOP
  - 00001 ADD
  - 00010 ADDU
  - 00011 SUB
  - 00100 AND
  - 00101 OR
  - 00110 XOR
  - 00111 NOR
  - 01000 SLT (signed)
  - 01001 SLTU
  - 01010 SLL
  - 01011 SRL
  - 01100 SRA
  - 01101 LUI (src2_i << WIDTH/2)
  - 01110 MFHI
  - 01111 MFLO
  - 10000 MTHI
  - 10001 MTLO
  - 10010 MULT
  - 10011 MULTU
  - 10100 DIV
  - 10101 DIVU
  - others: NOP
- Shifts: B shifted by src1_i[SHW-1:0].
- Combinational ops: result_o valid the same cycle regardless of valid_i; no state change.
- Result for non-result ops: result_o = 0 for NOP, MTHI/MTLO, MULT*, DIV*.
- ovf_o:
  - ADD: operand signs equal and result sign differs.
  - SUB: operand signs differ and result sign differs from A.
  - ovf_o = 0 for all other ops. The result is still produced on overflow; trap handling lives outside this block.
- MFHI/MFLO: result_o = hi_o/lo_o. Legal only when ready_o=1; control must stall otherwise. While busy, result_o = 0.
- MTHI/MTLO: on a clock edge with valid_i && ready_o, HI/LO <= src1_i. Next cycle hi_o/lo_o show the new value.
- FSM states IDLE, MUL, DIV, FIX. ready_o = (state == IDLE).
- IDLE:
  - valid_i && MULT*: latch |A|, |B| (raw for MULTU) and sign flag; counter <= WIDTH-1; go to MUL.
  - DIV*, B != 0: same latch; go to DIV.
  - DIV*, B == 0: no iteration. HI <= A, LO <= all-ones, done_o pulses next cycle, stay IDLE.
- MUL: one shift-add step per cycle (2·WIDTH accumulator). After WIDTH steps go to FIX.
- DIV: one restoring step per cycle (quotient bit + partial remainder). After WIDTH steps go to FIX.
- FIX:
  - Apply signs: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
  - Write {HI,LO} = product, or HI = remainder, LO = quotient.
  - Assert done_o for exactly this cycle; return to IDLE.
- Latency: valid_i at edge N → done_o high during cycle N+WIDTH+1. HI/LO visible from cycle N+WIDTH+2, the same cycle ready_o returns to 1.
- Requests while ready_o=0 are ignored. No queueing.
- Signed DIV of min / -1: quotient wraps to min, remainder 0. No exception.
- Reset (any time, including mid-operation): state IDLE, HI=0, LO=0, counter=0, accumulators=0.
  - Outputs after reset: ready_o=1, done_o=0, hi_o=lo_o=0.
  - result_o/zero_o/ovf_o follow inputs combinationally.
  - An in-flight op is discarded.

Test Plan:
- ADD with WIDTH=32: 0x7FFFFFFF + 1 → result_o=0x80000000, ovf_o=1, zero_o=0. SUB 5−5 → result_o=0, zero_o=1, ovf_o=0.
- SRA of 0x80000000 by src1_i=4 → result_o=0xF8000000. SRL → 0x08000000. SLT(−1,1)=1, SLTU(−1,1)=0.
- MULT −3 × 7 → ready_o low 33 cycles, done_o single pulse at cycle 33, HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULTU 0xFFFFFFFF² → HI=0xFFFFFFFE, LO=0x00000001.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 → done_o next cycle, HI=7, LO=0xFFFFFFFF.
- Assert rst_i low at cycle 10 of a MULT → ready_o=1, hi_o=lo_o=0 immediately. No done_o afterwards.
- MTHI 0x1234 then MFHI → result_o=0x1234. A MULT issued while busy is ignored (HI/LO reflect only the first op). Rerun the MULT case with WIDTH=16 → latency 17 cycles.

Source files
------------

// File: rtl/alu_muldiv.sv
// EX-stage ALU: single-cycle integer ops plus an iterative multiply/divide unit
// that writes the architectural HI/LO pair through a valid/ready/done handshake.
module alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [4:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             ovf_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_ADD   = 5'b00001;
    localparam logic [4:0] OP_ADDU  = 5'b00010;
    localparam logic [4:0] OP_SUB   = 5'b00011;
    localparam logic [4:0] OP_AND   = 5'b00100;
    localparam logic [4:0] OP_OR    = 5'b00101;
    localparam logic [4:0] OP_XOR   = 5'b00110;
    localparam logic [4:0] OP_NOR   = 5'b00111;
    localparam logic [4:0] OP_SLT   = 5'b01000;
    localparam logic [4:0] OP_SLTU  = 5'b01001;
    localparam logic [4:0] OP_SLL   = 5'b01010;
    localparam logic [4:0] OP_SRL   = 5'b01011;
    localparam logic [4:0] OP_SRA   = 5'b01100;
    localparam logic [4:0] OP_LUI   = 5'b01101;
    localparam logic [4:0] OP_MFHI  = 5'b01110;
    localparam logic [4:0] OP_MFLO  = 5'b01111;
    localparam logic [4:0] OP_MTHI  = 5'b10000;
    localparam logic [4:0] OP_MTLO  = 5'b10001;
    localparam logic [4:0] OP_MULT  = 5'b10010;
    localparam logic [4:0] OP_MULTU = 5'b10011;
    localparam logic [4:0] OP_DIV   = 5'b10100;
    localparam logic [4:0] OP_DIVU  = 5'b10101;

    localparam logic [SHW-1:0] CNT_INIT = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

    state_e             state_q;
    logic [SHW-1:0]     cnt_q;
    logic [WIDTH-1:0]   opd_q;      // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc_q;      // {partial, multiplier} or {remainder, quotient}
    logic               neg_q;
    logic               rem_neg_q;
    logic               is_div_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    // ---------------- single-cycle datapath ----------------
    logic [WIDTH-1:0] add_res;
    logic [WIDTH-1:0] sub_res;
    logic [SHW-1:0]   shamt;

    assign add_res = src1_i + src2_i;
    assign sub_res = src1_i - src2_i;
    assign shamt   = src1_i[SHW-1:0];

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        result_o = '0;
        ovf_o    = 1'b0;
        case (ctrl_i)
            OP_ADD: begin
                result_o = add_res;
                ovf_o    = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) &&
                           (add_res[WIDTH-1] != src1_i[WIDTH-1]);
            end
            OP_ADDU: result_o = add_res;
            OP_SUB: begin
                result_o = sub_res;
                ovf_o    = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) &&
                           (sub_res[WIDTH-1] != src1_i[WIDTH-1]);
            end
            OP_AND:  result_o = src1_i & src2_i;
            OP_OR:   result_o = src1_i | src2_i;
            OP_XOR:  result_o = src1_i ^ src2_i;
            OP_NOR:  result_o = ~(src1_i | src2_i);
            OP_SLT:  result_o = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            OP_SLTU: result_o = {{(WIDTH-1){1'b0}}, (src1_i < src2_i)};
            OP_SLL:  result_o = src2_i << shamt;
            OP_SRL:  result_o = src2_i >> shamt;
            OP_SRA:  result_o = $signed(src2_i) >>> shamt;
            OP_LUI:  result_o = src2_i << (WIDTH / 2);
            OP_MFHI: result_o = ready_o ? hi_q : '0;
            OP_MFLO: result_o = ready_o ? lo_q : '0;
            default: result_o = '0;
        endcase
    end

    assign zero_o  = (result_o == '0);
    assign ready_o = (state_q == S_IDLE);
    assign done_o  = done_q;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

    // ---------------- multiply/divide datapath ----------------
    logic             op_signed;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign op_signed = (ctrl_i == OP_MULT) || (ctrl_i == OP_DIV);
    assign a_mag     = (op_signed && src1_i[WIDTH-1]) ? -src1_i : src1_i;
    assign b_mag     = (op_signed && src2_i[WIDTH-1]) ? -src2_i : src2_i;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);

    // Restoring step: shift the next dividend bit in, subtract only if it fits.
    assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign rem_ge   = (rem_sh >= {1'b0, opd_q});
    assign rem_next = WIDTH'(rem_ge ? (rem_sh - {1'b0, opd_q}) : rem_sh);

    assign prod_fix = neg_q     ? -acc_q                   : acc_q;
    assign quo_fix  = neg_q     ? -acc_q[WIDTH-1:0]        : acc_q[WIDTH-1:0];
    assign rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH]  : acc_q[2*WIDTH-1:WIDTH];

    // NOTE: sequential state uses non-blocking assignments only, and every register is reset here.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            opd_q     <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            is_div_q  <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (valid_i) begin
                        case (ctrl_i)
                            OP_MTHI: hi_q <= src1_i;
                            OP_MTLO: lo_q <= src1_i;
                            OP_MULT, OP_MULTU: begin
                                opd_q    <= a_mag;
                                acc_q    <= {{WIDTH{1'b0}}, b_mag};
                                neg_q    <= op_signed && (src1_i[WIDTH-1] ^ src2_i[WIDTH-1]);
                                is_div_q <= 1'b0;
                                cnt_q    <= CNT_INIT;
                                state_q  <= S_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                if (src2_i == '0) begin
                                    hi_q   <= src1_i;
                                    lo_q   <= '1;
                                    done_q <= 1'b1;
                                end else begin
                                    opd_q     <= b_mag;
                                    acc_q     <= {{WIDTH{1'b0}}, a_mag};
                                    neg_q     <= op_signed && (src1_i[WIDTH-1] ^ src2_i[WIDTH-1]);
                                    rem_neg_q <= op_signed && src1_i[WIDTH-1];
                                    is_div_q  <= 1'b1;
                                    cnt_q     <= CNT_INIT;
                                    state_q   <= S_DIV;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL, S_DIV: begin
                    if (state_q == S_MUL) acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
                    else                  acc_q <= {rem_next, acc_q[WIDTH-2:0], rem_ge};
                    if (cnt_q == '0) begin
                        state_q <= S_FIX;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_FIX: begin
                    if (is_div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
